// File: rtl/asf_pkg.sv
// Shared types and pointer helpers for the nonuniform-sample async FIFO read side.
package asf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_OVF   = 2'd3
  } asf_state_t;

  function automatic int unsigned depth_of(input int unsigned bit_cnt);
    return 32'd1 << bit_cnt;
  endfunction

  // Pointer difference modulo a power-of-two depth.
  function automatic int unsigned ptr_diff(input int unsigned a, input int unsigned b,
                                           input int unsigned depth);
    return (a - b) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/asf_backlog_acc.sv
// Unread-sample accumulator: backlog += new samples - reads, with overwrite detection.
module asf_backlog_acc #(
  parameter int BIT_CNT = 3,
  parameter int OVF_LVL = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BIT_CNT-1:0] nsamp_raw,
  input  logic               rd_en,
  input  logic               clear,
  input  logic [BIT_CNT-1:0] pend_next,
  output logic [BIT_CNT:0]   backlog,
  output logic               ovf_det
);

  localparam logic [BIT_CNT:0] OVF_THR = (BIT_CNT+1)'(OVF_LVL);

  logic [BIT_CNT:0] backlog_q;
  logic [BIT_CNT:0] backlog_d;
  logic [BIT_CNT:0] bl_next;

  assign bl_next = backlog_q + {1'b0, nsamp_raw} - {{BIT_CNT{1'b0}}, rd_en};

  // A backlog that no longer matches the pointer distance means the writer lapped us.
  assign ovf_det = (bl_next > OVF_THR) || (bl_next != {1'b0, pend_next});

  always_comb begin
    backlog_d = bl_next;
    if (clear) backlog_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) backlog_q <= '0;
    else       backlog_q <= backlog_d;
  end

  assign backlog = backlog_q;

endmodule

// File: rtl/asf_read_sched.sv
// Read scheduler: tracks new write-side samples and issues one FIFO read per cycle
// into a valid/ready output register, with sticky overflow and resync.
module asf_read_sched
  import asf_pkg::*;
#(
  parameter int BIT_CNT   = 3,
  parameter int DATA_W    = 8,
  parameter int PRIME_CYC = 2,
  parameter int OVF_LVL   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [BIT_CNT-1:0] em1,
  input  logic [BIT_CNT-1:0] s,
  input  logic [DATA_W-1:0]  rdata,
  output logic [BIT_CNT-1:0] raddr,
  output logic               rd_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [BIT_CNT-1:0] nsamp,
  output logic [BIT_CNT:0]   backlog,
  output logic               ovf,
  input  logic               ovf_clr,
  output logic [1:0]         state
);

  localparam int unsigned DEPTH = depth_of(BIT_CNT);
  localparam int          PCW   = $clog2(PRIME_CYC + 1);

  // Handshake: a sample transfers on a cycle where out_valid & out_ready are both 1;
  // out_data is held while out_valid & !out_ready, and out_valid never drops unaccepted
  // except on reset, resync or overflow.

  asf_state_t         state_q, state_d;
  logic [PCW-1:0]     prime_cnt_q, prime_cnt_d;
  logic [BIT_CNT-1:0] lrd_q, lrd_d;
  logic [BIT_CNT-1:0] nsamp_q;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;

  logic [BIT_CNT-1:0] pend, pend_next, nsamp_raw, lrd_adv, acc_nsamp;
  logic               rd, ovf_det, acc_clear;

  assign pend      = BIT_CNT'(ptr_diff(32'(em1), 32'(lrd_q), DEPTH));
  assign nsamp_raw = BIT_CNT'(ptr_diff(32'(em1), 32'(s), DEPTH));
  assign rd        = (state_q == ST_RUN) && (pend != '0) && (!out_valid_q || out_ready);
  assign lrd_adv   = lrd_q + BIT_CNT'(rd);
  assign pend_next = BIT_CNT'(ptr_diff(32'(em1), 32'(lrd_adv), DEPTH));

  // Backlog is frozen while in overflow and zeroed throughout priming.
  assign acc_nsamp = (state_q == ST_OVF) ? '0 : nsamp_raw;
  assign acc_clear = (state_q == ST_PRIME) || ((state_q == ST_OVF) && ovf_clr);

  asf_backlog_acc #(
    .BIT_CNT (BIT_CNT),
    .OVF_LVL (OVF_LVL)
  ) u_acc (
    .clk       (clk),
    .reset     (reset),
    .nsamp_raw (acc_nsamp),
    .rd_en     (rd),
    .clear     (acc_clear),
    .pend_next (pend_next),
    .backlog   (backlog),
    .ovf_det   (ovf_det)
  );

  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    lrd_d       = lrd_adv;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (rd) begin
      out_data_d  = rdata;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_PRIME: begin
        lrd_d       = em1;
        out_valid_d = 1'b0;
        if (prime_cnt_q == PCW'(PRIME_CYC - 1)) begin
          prime_cnt_d = '0;
          state_d     = enable ? ST_RUN : ST_IDLE;
        end else begin
          prime_cnt_d = prime_cnt_q + 1'b1;
        end
      end
      ST_RUN, ST_IDLE: begin
        if (ovf_det) begin
          state_d     = ST_OVF;
          ovf_d       = 1'b1;
          out_valid_d = 1'b0;
        end else begin
          state_d = enable ? ST_RUN : ST_IDLE;
        end
      end
      ST_OVF: begin
        out_valid_d = 1'b0;
        if (ovf_clr) begin
          state_d     = ST_PRIME;
          prime_cnt_d = '0;
          ovf_d       = 1'b0;
          lrd_d       = em1;
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PRIME;
      prime_cnt_q <= '0;
      lrd_q       <= '1;
      nsamp_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      lrd_q       <= lrd_d;
      nsamp_q     <= nsamp_raw;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign raddr     = lrd_q + 1'b1;
  assign rd_en     = rd;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign nsamp     = nsamp_q;
  assign ovf       = ovf_q;
  assign state     = state_q;

endmodule

// File: tb/tb_asf_read_sched.sv
// Bench for asf_read_sched: directed scenarios plus random traffic against a
// cycle-level behavioural model of the scheduler.
module tb_asf_read_sched;

  localparam int DEPTH     = 8;
  localparam int PRIME_CYC = 2;
  localparam int OVF_LVL   = 7;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [2:0] em1_r = 3'd7;
  logic [2:0] s_r = 3'd7;
  logic       out_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata;
  logic [2:0] raddr;
  logic       rd_en, out_valid, ovf;
  logic [7:0] out_data;
  logic [2:0] nsamp;
  logic [3:0] backlog;
  logic [1:0] state;

  assign rdata = mem[raddr];
  always @(posedge clk) s_r <= em1_r;

  asf_read_sched dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .em1       (em1_r),
    .s         (s_r),
    .rdata     (rdata),
    .raddr     (raddr),
    .rd_en     (rd_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .nsamp     (nsamp),
    .backlog   (backlog),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .state     (state)
  );

  // scoreboard counters
  int n_total = 0;
  int n_pass  = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // behavioural model: 0=IDLE 1=PRIME 2=RUN 3=OVF
  int m_st = 1, m_pc = 0, m_lrd = 7, m_bl = 0, m_ns = 0, m_ovf = 0, m_ov = 0, m_od = 0;

  function automatic int m_pend();
    return (int'(em1_r) - m_lrd + DEPTH) % DEPTH;
  endfunction

  function automatic int m_rd_now();
    return (m_st == 2 && m_pend() != 0 && (m_ov == 0 || out_ready)) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    int raw, rd;
    if (reset) begin
      m_st = 1; m_pc = 0; m_lrd = 7; m_bl = 0; m_ns = 0; m_ovf = 0; m_ov = 0; m_od = 0;
    end else begin
      raw  = (int'(em1_r) - int'(s_r) + DEPTH) % DEPTH;
      rd   = m_rd_now();
      m_ns = raw;
      case (m_st)
        1: begin
          m_lrd = int'(em1_r); m_bl = 0; m_ov = 0;
          if (m_pc == PRIME_CYC - 1) begin m_pc = 0; m_st = enable ? 2 : 0; end
          else m_pc++;
        end
        0, 2: begin
          if (rd == 1) begin m_od = int'(mem[(m_lrd + 1) % DEPTH]); m_ov = 1; end
          else if (m_ov == 1 && out_ready) m_ov = 0;
          m_lrd = (m_lrd + rd) % DEPTH;
          m_bl  = m_bl + raw - rd;
          if (m_bl > OVF_LVL) begin m_st = 3; m_ovf = 1; m_ov = 0; end
          else m_st = enable ? 2 : 0;
        end
        default: begin
          m_ov = 0;
          if (ovf_clr) begin m_st = 1; m_pc = 0; m_ovf = 0; m_lrd = int'(em1_r); m_bl = 0; end
        end
      endcase
    end
  end

  // compare process
  always @(negedge clk) begin
    if (check_en) begin
      chk("state",     int'(state),     m_st);
      chk("raddr",     int'(raddr),     (m_lrd + 1) % DEPTH);
      chk("rd_en",     int'(rd_en),     m_rd_now());
      chk("out_valid", int'(out_valid), m_ov);
      chk("out_data",  int'(out_data),  m_od);
      chk("nsamp",     int'(nsamp),     m_ns);
      chk("backlog",   int'(backlog),   m_bl);
      chk("ovf",       int'(ovf),       m_ovf);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic publish(input int n);
    for (int i = 1; i <= n; i++) mem[(int'(em1_r) + i) % DEPTH] = 8'($urandom);
    em1_r = em1_r + 3'(n);
  endtask

  initial begin
    int r;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

    // 1: reset and priming
    tick();
    check_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t1_state0", int'(state), 1);
    chk("t1_raddr", int'(raddr), 0);
    chk("t1_rd_en", int'(rd_en), 0);
    chk("t1_backlog", int'(backlog), 0);
    chk("t1_out_valid", int'(out_valid), 0);
    tick(); @(negedge clk); chk("t1_state1", int'(state), 1);
    tick(); @(negedge clk); chk("t1_state2", int'(state), 2);

    // 2: three new samples, drained back-to-back
    tick(); publish(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_rd_en", int'(rd_en), 1);
      chk("t2_raddr", int'(raddr), i);
      if (i == 1) begin
        chk("t2_nsamp", int'(nsamp), 3);
        chk("t2_backlog", int'(backlog), 2);
        chk("t2_data0", int'(out_data), int'(mem[0]));
      end
      tick();
    end
    @(negedge clk);
    chk("t2_no_rd", int'(rd_en), 0);
    chk("t2_drained", int'(backlog), 0);
    chk("t2_data2", int'(out_data), int'(mem[2]));

    // 3: backpressure
    repeat (2) tick();
    out_ready = 1'b0; publish(3);
    @(negedge clk); chk("t3_first_rd", int'(rd_en), 1); chk("t3_first_addr", int'(raddr), 3);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk("t3_stall_rd", int'(rd_en), 0);
      chk("t3_hold_valid", int'(out_valid), 1);
      chk("t3_hold_data", int'(out_data), int'(mem[3]));
      chk("t3_hold_addr", int'(raddr), 4);
      chk("t3_hold_bl", int'(backlog), 2);
    end
    tick(); out_ready = 1'b1;
    @(negedge clk); chk("t3_rd4", int'(rd_en), 1); chk("t3_addr4", int'(raddr), 4);
    tick(); @(negedge clk); chk("t3_rd5", int'(rd_en), 1); chk("t3_addr5", int'(raddr), 5);
    tick(); @(negedge clk); chk("t3_done", int'(rd_en), 0); chk("t3_bl0", int'(backlog), 0);

    // 4: pointer wrap 6,7,0,1
    repeat (2) tick();
    publish(4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_rd_en", int'(rd_en), 1);
      chk("t4_raddr", int'(raddr), (6 + i) % 8);
      if (i == 1) chk("t4_nsamp", int'(nsamp), 4);
      tick();
    end
    @(negedge clk); chk("t4_bl0", int'(backlog), 0);

    // 5: overflow while idle, then resync
    tick(); enable = 1'b0;
    tick(); tick(); publish(4);
    tick(); publish(4);
    tick(); @(negedge clk);
    chk("t5_state_ovf", int'(state), 3);
    chk("t5_ovf", int'(ovf), 1);
    chk("t5_rd_en", int'(rd_en), 0);
    chk("t5_backlog8", int'(backlog), 8);
    tick(); enable = 1'b1; ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    @(negedge clk);
    chk("t5_prime", int'(state), 1);
    chk("t5_ovf_clr", int'(ovf), 0);
    chk("t5_resync_addr", int'(raddr), 2);
    chk("t5_resync_bl", int'(backlog), 0);
    tick(); tick(); @(negedge clk);
    chk("t5_run", int'(state), 2);
    chk("t5_run_bl", int'(backlog), 0);

    // 6: reset mid-drain
    tick(); publish(3);
    tick(); reset = 1'b1;
    @(negedge clk); chk("t6_pre_bl", int'(backlog), 2); chk("t6_pre_valid", int'(out_valid), 1);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("t6_state", int'(state), 1);
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_bl", int'(backlog), 0);
    chk("t6_nsamp", int'(nsamp), 0);
    chk("t6_data", int'(out_data), 0);
    chk("t6_raddr", int'(raddr), 0);
    chk("t6_ovf", int'(ovf), 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset     = ($urandom_range(0, 499) == 0);
      enable    = ((c % 300) < 240) ? ($urandom_range(0, 19) != 0) : 1'b0;
      out_ready = ($urandom_range(0, 9) < 7);
      ovf_clr   = ($urandom_range(0, 7) == 0);
      r = int'($urandom_range(0, 99));
      if (r >= 95)      publish(int'($urandom_range(4, 7)));
      else if (r >= 50) publish(int'($urandom_range(1, 3)));
    end

    tick();
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
